// File: rtl/retire_buffer.sv
// retire_buffer: in-order retire FIFO with id-based flush, registered stall and sticky overflow.
// Optional dead-entry drop counter is enabled by defining RETIRE_BUF_DROP_CNT_EN.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module retire_buffer #(
  parameter int DEPTH        = 8,
  parameter int STALL_THRESH = DEPTH - 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [`ADDRESS_WIDTH-1:0] in_address,
  input  logic [`ID_WIDTH-1:0]      in_id,
  input  logic                      in_valid,
  input  logic                      in_flush,
  input  logic [`ID_WIDTH-1:0]      in_flush_id,
  output logic                      stall_out,
  output logic [`ADDRESS_WIDTH-1:0] out_address,
  output logic [`ID_WIDTH-1:0]      out_id,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overflow
`ifdef RETIRE_BUF_DROP_CNT_EN
  ,
  output logic [15:0]               drop_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(STALL_THRESH);

  logic [`ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
  logic [`ID_WIDTH-1:0]      id_mem   [DEPTH];
  logic [DEPTH-1:0]          live;
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [CW-1:0]             count;
  logic [CW-1:0]             count_next;

  logic not_empty, head_live, drop, pop, rd_adv, full;
  logic push_req, push, push_lost, push_dead;

  assign not_empty   = (count != '0);
  assign head_live   = live[rd_ptr];
  assign out_valid   = not_empty & head_live;
  assign out_address = addr_mem[rd_ptr];
  assign out_id      = id_mem[rd_ptr];

  // A dead head leaves on its own every cycle; a live head needs the consumer.
  assign drop      = not_empty & ~head_live;
  assign pop       = out_valid & out_ready;
  assign rd_adv    = pop | drop;
  assign full      = (count == DEPTH_C);
  assign push_req  = in_valid & ~stall_out;
  assign push      = push_req & (~full | rd_adv);
  assign push_lost = push_req & full & ~rd_adv;
  assign push_dead = in_flush & (in_id == in_flush_id);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_next = count;
    if (push && !rd_adv)
      count_next = count + CW'(1);
    else if (!push && rd_adv)
      count_next = count - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments; the later push write to live
  // deliberately overrides the flush clear for the slot being written this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      stall_out <= 1'b0;
      overflow  <= 1'b0;
      live      <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (rd_adv)
        rd_ptr <= rd_ptr + PW'(1);
      count     <= count_next;
      stall_out <= (count_next >= THRESH_C);
      if (push_lost)
        overflow <= 1'b1;
      if (in_flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (id_mem[i] == in_flush_id)
            live[i] <= 1'b0;
        end
      end
      if (push)
        live[wr_ptr] <= ~push_dead;
    end
  end

  // NOTE: payload storage has no reset; live and count already mark every slot as empty.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_address;
      id_mem[wr_ptr]   <= in_id;
    end
  end

`ifdef RETIRE_BUF_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_retire_buffer.sv
// Self-checking bench for retire_buffer: table-driven cycle vectors plus directed
// sequences for stall, forced overflow and asynchronous reset.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module tb_retire_buffer;

  localparam int AW = `ADDRESS_WIDTH;
  localparam int IW = `ID_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] in_address;
  logic [IW-1:0] in_id;
  logic          in_valid;
  logic          in_flush;
  logic [IW-1:0] in_flush_id;
  logic          stall_out;
  logic [AW-1:0] out_address;
  logic [IW-1:0] out_id;
  logic          out_valid;
  logic          out_ready;
  logic          overflow;
`ifdef RETIRE_BUF_DROP_CNT_EN
  logic [15:0]   drop_count;
`endif

  retire_buffer #(.DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_address  (in_address),
    .in_id       (in_id),
    .in_valid    (in_valid),
    .in_flush    (in_flush),
    .in_flush_id (in_flush_id),
    .stall_out   (stall_out),
    .out_address (out_address),
    .out_id      (out_id),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow)
`ifdef RETIRE_BUF_DROP_CNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic          fl;
    logic [IW-1:0] fid;
    logic          rdy;
    logic          ev;
    logic [IW-1:0] eid;
    logic [AW-1:0] eaddr;
    int            ecnt;
    int            edrop;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  function automatic vec_t mk(logic iv, int id, int addr, logic fl, int fid, logic rdy,
                              logic ev, int eid, int eaddr, int ecnt, int edrop);
    vec_t v;
    v.iv = iv;  v.id = IW'(id);   v.addr = AW'(addr);
    v.fl = fl;  v.fid = IW'(fid); v.rdy = rdy;
    v.ev = ev;  v.eid = IW'(eid); v.eaddr = AW'(eaddr);
    v.ecnt = ecnt; v.edrop = edrop;
    return v;
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; in_id = '0; in_address = '0;
    in_flush = 1'b0; in_flush_id = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Drive in_valid continuously; a new id is presented only when the previous one was taken.
  task automatic fill_until_stall(input int cycles, output int next_id);
    next_id = 1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (!stall_out) begin
        in_valid   = 1'b1;
        in_id      = IW'(next_id);
        in_address = AW'(32'h100 + next_id);
        next_id++;
      end
    end
  endtask

  vec_t vecs [15];
  int   nid;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Step-by-step: latency, flush of ids {1,2,1,4}, flush+push, flush+pop of same head.
    vecs[0]  = mk(1, 3, 'h10, 0, 0, 1,  1, 3, 'h10, 1, 0);
    vecs[1]  = mk(0, 0, 0,    0, 0, 1,  0, 0, 0,    0, 0);
    vecs[2]  = mk(1, 1, 'h20, 0, 0, 0,  1, 1, 'h20, 1, 0);
    vecs[3]  = mk(1, 2, 'h21, 0, 0, 0,  1, 1, 'h20, 2, 0);
    vecs[4]  = mk(1, 1, 'h22, 0, 0, 0,  1, 1, 'h20, 3, 0);
    vecs[5]  = mk(1, 4, 'h23, 0, 0, 0,  1, 1, 'h20, 4, 0);
    vecs[6]  = mk(0, 0, 0,    1, 1, 0,  0, 0, 0,    4, 0);
    vecs[7]  = mk(0, 0, 0,    0, 0, 1,  1, 2, 'h21, 3, 1);
    vecs[8]  = mk(0, 0, 0,    0, 0, 1,  0, 0, 0,    2, 1);
    vecs[9]  = mk(0, 0, 0,    0, 0, 1,  1, 4, 'h23, 1, 2);
    vecs[10] = mk(0, 0, 0,    0, 0, 1,  0, 0, 0,    0, 2);
    vecs[11] = mk(1, 5, 'h30, 1, 5, 1,  0, 0, 0,    1, 2);
    vecs[12] = mk(0, 0, 0,    0, 0, 1,  0, 0, 0,    0, 3);
    vecs[13] = mk(1, 6, 'h31, 0, 0, 0,  1, 6, 'h31, 1, 3);
    vecs[14] = mk(0, 0, 0,    1, 6, 1,  0, 0, 0,    0, 3);

    reset = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset stall_out", stall_out, 0);
    check("reset overflow", overflow, 0);
    check("reset count", dut.count, 0);
`ifdef RETIRE_BUF_DROP_CNT_EN
    check("reset drop_count", drop_count, 0);
`endif
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      in_valid = vecs[i].iv; in_id = vecs[i].id; in_address = vecs[i].addr;
      in_flush = vecs[i].fl; in_flush_id = vecs[i].fid; out_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("step%0d out_valid", i), out_valid, vecs[i].ev);
      if (vecs[i].ev) begin
        check($sformatf("step%0d out_id", i), out_id, vecs[i].eid);
        check($sformatf("step%0d out_address", i), out_address, vecs[i].eaddr);
      end
      check($sformatf("step%0d count", i), dut.count, vecs[i].ecnt);
      check($sformatf("step%0d stall_out", i), stall_out, (vecs[i].ecnt >= 7));
`ifdef RETIRE_BUF_DROP_CNT_EN
      check($sformatf("step%0d drop_count", i), drop_count, vecs[i].edrop);
`endif
    end
    check("table overflow", overflow, 0);

    // Stall: continuous push with consumer blocked stops at 7 entries.
    do_reset();
    fill_until_stall(12, nid);
    @(negedge clk);
    check("stall accepted ids", nid, 8);
    check("stall count", dut.count, 7);
    check("stall stall_out", stall_out, 1);
    check("stall overflow", overflow, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      check($sformatf("drain%0d out_valid", k), out_valid, 1);
      check($sformatf("drain%0d out_id", k), out_id, k);
      check($sformatf("drain%0d out_address", k), out_address, 32'h100 + k);
      if (k == 1) check("drain stall before pop", stall_out, 1);
      if (k == 2) check("drain stall after pop", stall_out, 0);
      @(negedge clk);
    end
    check("drain empty valid", out_valid, 0);
    check("drain empty count", dut.count, 0);

    // Forced overflow: bypass the stall to reach full, then push once more.
    do_reset();
    fill_until_stall(9, nid);
    @(negedge clk);
    force dut.stall_out = 1'b0;
    in_valid = 1'b1; in_id = IW'(8); in_address = AW'(32'h108);
    @(negedge clk);
    check("ovf full count", dut.count, 8);
    check("ovf before push", overflow, 0);
    in_id = IW'(9); in_address = AW'(32'h109);
    @(negedge clk);
    check("ovf flag set", overflow, 1);
    check("ovf count unchanged", dut.count, 8);
    in_valid = 1'b0;
    release dut.stall_out;
    @(negedge clk);
    check("ovf sticky", overflow, 1);
    check("ovf stall_out", stall_out, 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("ovf drain%0d out_id", k), out_id, k);
      check($sformatf("ovf drain%0d out_address", k), out_address, 32'h100 + k);
      @(negedge clk);
    end
    check("ovf drained count", dut.count, 0);
    check("ovf still sticky", overflow, 1);

    // Asynchronous reset with entries held.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_id = IW'(k); in_address = AW'(32'h200 + k);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("pre-reset count", dut.count, 4);
    check("pre-reset out_valid", out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset stall_out", stall_out, 0);
    check("async reset count", dut.count, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post-reset out_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
